// File: rtl/chan_mean_pkg.sv
// Shared constants and FSM state type for the per-channel running-mean engine.
package chan_mean_pkg;

    localparam int unsigned NUM_CHANNELS = 7;
    localparam int unsigned SAMPLE_BITS  = 8;
    localparam int unsigned WINDOW       = 10;
    localparam int unsigned SUM_BITS     = SAMPLE_BITS + 4;
    localparam int unsigned FILL_BITS    = 4;
    localparam int unsigned CHAN_BITS    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DIV    = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock.
//   start     : load dividend/divisor (ignored while busy is not checked; caller sequences it)
//   dividend  : DIVIDEND_BITS numerator
//   divisor   : DIVISOR_BITS denominator, must be nonzero
//   done      : one-cycle pulse after the last quotient bit is produced
//   quotient  : low QUO_BITS of the quotient, valid from done until next start
//   remainder : remainder, valid from done until next start
module seq_divider #(
    parameter int unsigned DIVIDEND_BITS = 12,
    parameter int unsigned DIVISOR_BITS  = 4,
    parameter int unsigned QUO_BITS      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIVIDEND_BITS-1:0] dividend,
    input  logic [DIVISOR_BITS-1:0]  divisor,
    output logic                     done,
    output logic [QUO_BITS-1:0]      quotient,
    output logic [DIVISOR_BITS-1:0]  remainder
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_BITS + 1);

    // quo_q starts as the dividend and shifts left; quotient bits enter at the bottom
    logic [DIVIDEND_BITS-1:0] quo_q;
    logic [DIVISOR_BITS-1:0]  rem_q;
    logic [DIVISOR_BITS-1:0]  divisor_q;
    logic [CNT_W-1:0]         count_q;
    logic [DIVISOR_BITS:0]    partial_c;
    logic                     fits_c;

    // Trial subtraction for the current bit
    always_comb begin
        partial_c = {rem_q, quo_q[DIVIDEND_BITS-1]};
        fits_c    = partial_c >= {1'b0, divisor_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo_q     <= dividend;
                rem_q     <= '0;
                divisor_q <= divisor;
                count_q   <= CNT_W'(DIVIDEND_BITS);
            end else if (count_q != '0) begin
                quo_q   <= {quo_q[DIVIDEND_BITS-2:0], fits_c};
                rem_q   <= fits_c ? DIVISOR_BITS'(partial_c - {1'b0, divisor_q})
                                  : DIVISOR_BITS'(partial_c);
                count_q <= count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q[QUO_BITS-1:0];
    assign remainder = rem_q;

endmodule

// File: rtl/channel_mean_engine.sv
// Per-channel sliding-window mean: keeps a running sum and fill count for each
// channel, updates it with one entering/evicted sample pair, then divides.
//   in_valid/in_ready/in_chan/in_new/in_old : sample input handshake
//   out_valid/out_ready                      : result handshake
//   out_chan/out_mean/out_rem/out_warm       : result payload, stable while out_valid
//   err_chan                                 : one-cycle pulse on an out-of-range channel
module channel_mean_engine #(
    parameter int unsigned NUM_CHANNELS = chan_mean_pkg::NUM_CHANNELS,
    parameter int unsigned SAMPLE_BITS  = chan_mean_pkg::SAMPLE_BITS,
    parameter int unsigned WINDOW       = chan_mean_pkg::WINDOW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_chan,
    input  logic [SAMPLE_BITS-1:0] in_new,
    input  logic [SAMPLE_BITS-1:0] in_old,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_chan,
    output logic [SAMPLE_BITS-1:0] out_mean,
    output logic [3:0]             out_rem,
    output logic                   out_warm,
    output logic                   err_chan
);

    import chan_mean_pkg::*;

    localparam int unsigned SUM_W  = SAMPLE_BITS + 4;
    localparam int unsigned FILL_W = 4;

    state_t                   state;
    logic [2:0]               chan_q;
    logic [SAMPLE_BITS-1:0]   new_q;
    logic [SAMPLE_BITS-1:0]   old_q;
    logic                     warm_q;

    logic [SUM_W-1:0]         sum_mem  [NUM_CHANNELS];
    logic [FILL_W-1:0]        fill_mem [NUM_CHANNELS];

    logic [SUM_W-1:0]         cur_sum_c;
    logic [FILL_W-1:0]        cur_fill_c;
    logic                     full_c;
    logic [SUM_W-1:0]         new_sum_c;
    logic [FILL_W-1:0]        new_fill_c;
    logic                     div_start_c;

    logic                     div_done;
    logic [SAMPLE_BITS-1:0]   div_quo;
    logic [FILL_W-1:0]        div_rem;

    // Window update for the latched channel; the evicted sample only counts once full
    always_comb begin
        cur_sum_c   = sum_mem[chan_q];
        cur_fill_c  = fill_mem[chan_q];
        full_c      = (cur_fill_c == FILL_W'(WINDOW));
        new_sum_c   = cur_sum_c + SUM_W'(new_q) - (full_c ? SUM_W'(old_q) : '0);
        new_fill_c  = full_c ? cur_fill_c : cur_fill_c + FILL_W'(1);
        div_start_c = (state == ST_UPDATE);
    end

    // Divider is loaded on the UPDATE edge with the same values written to storage
    seq_divider #(
        .DIVIDEND_BITS (SUM_W),
        .DIVISOR_BITS  (FILL_W),
        .QUO_BITS      (SAMPLE_BITS)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_c),
        .dividend  (new_sum_c),
        .divisor   (new_fill_c),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Control FSM, per-channel storage and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            chan_q    <= '0;
            new_q     <= '0;
            old_q     <= '0;
            warm_q    <= 1'b0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_mean  <= '0;
            out_rem   <= '0;
            out_warm  <= 1'b0;
            err_chan  <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                sum_mem[i]  <= '0;
                fill_mem[i] <= '0;
            end
        end else begin
            err_chan <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (32'(in_chan) < NUM_CHANNELS) begin
                            chan_q   <= in_chan;
                            new_q    <= in_new;
                            old_q    <= in_old;
                            in_ready <= 1'b0;
                            state    <= ST_UPDATE;
                        end else begin
                            err_chan <= 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    sum_mem[chan_q]  <= new_sum_c;
                    fill_mem[chan_q] <= new_fill_c;
                    warm_q           <= (new_fill_c == FILL_W'(WINDOW));
                    state            <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_done) begin
                        out_valid <= 1'b1;
                        out_chan  <= chan_q;
                        out_mean  <= div_quo;
                        out_rem   <= div_rem;
                        out_warm  <= warm_q;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_chan  <= '0;
                        out_mean  <= '0;
                        out_rem   <= '0;
                        out_warm  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_mean_engine.sv
// Directed bench for channel_mean_engine: latency, mean/remainder values,
// window eviction, backpressure, bad channel and mid-divide reset.
module tb_channel_mean_engine;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_chan;
    logic [7:0] in_new;
    logic [7:0] in_old;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_chan;
    logic [7:0] out_mean;
    logic [3:0] out_rem;
    logic       out_warm;
    logic       err_chan;

    int checks   = 0;
    int failures = 0;

    channel_mean_engine dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_chan   (in_chan),
        .in_new    (in_new),
        .in_old    (in_old),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_mean  (out_mean),
        .out_rem   (out_rem),
        .out_warm  (out_warm),
        .err_chan  (err_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample and return just after the edge that accepts it
    task automatic xfer(input logic [2:0] c, input logic [7:0] nv, input logic [7:0] ov);
        int waited;
        waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_chan  = c;
        in_new   = nv;
        in_old   = ov;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_new   = 8'hEE;
        in_old   = 8'hEE;
    endtask

    // Count edges from the transfer until out_valid, then compare the payload
    task automatic expect_result(input string tag, input logic [2:0] c,
                                 input logic [7:0] m, input logic [3:0] r, input logic w);
        int lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd14);
        chk({tag, "_chan"}, 32'(out_chan), 32'(c));
        chk({tag, "_mean"}, 32'(out_mean), 32'(m));
        chk({tag, "_rem"},  32'(out_rem),  32'(r));
        chk({tag, "_warm"}, 32'(out_warm), 32'(w));
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    // Handshake happens on the next edge (out_ready already high)
    task automatic take_result(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_mean_clear"}, 32'(out_mean), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int s;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_chan   = 3'd0;
        in_new    = 8'd0;
        in_old    = 8'd0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err_chan", 32'(err_chan), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single sample on channel 2
        xfer(3'd2, 8'd100, 8'd0);
        expect_result("ch2", 3'd2, 8'd100, 4'd0, 1'b0);
        take_result("ch2");

        // Fill channel 0 with 1..10; in_old is garbage and must be ignored while filling
        for (int k = 1; k <= 10; k++) begin
            s = k * (k + 1) / 2;
            xfer(3'd0, 8'(k), 8'hAA);
            expect_result($sformatf("fill%0d", k), 3'd0, 8'(s / k), 4'(s % k), (k == 10));
            take_result($sformatf("fill%0d", k));
        end

        // Full window: 55 + 255 - 1 = 309 -> 30 r 9
        xfer(3'd0, 8'd255, 8'd1);
        expect_result("evict", 3'd0, 8'd30, 4'd9, 1'b1);
        take_result("evict");

        // Backpressure: hold result for 20 cycles
        out_ready = 1'b0;
        xfer(3'd1, 8'd7, 8'd0);
        expect_result("stall", 3'd1, 8'd7, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall_mean_%0d", i), 32'(out_mean), 32'd7);
            chk($sformatf("stall_chan_%0d", i), 32'(out_chan), 32'd1);
            chk($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        take_result("stall");

        // Out-of-range channel: pulse err_chan, stay idle, no result
        xfer(3'd7, 8'd99, 8'd99);
        @(negedge clk);
        chk("bad_err_pulse", 32'(err_chan), 32'd1);
        chk("bad_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bad_err_drop", 32'(err_chan), 32'd0);
        expect_quiet("bad_no_output", 20);
        xfer(3'd3, 8'd10, 8'd0);
        expect_result("after_bad", 3'd3, 8'd10, 4'd0, 1'b0);
        take_result("after_bad");

        // Reset in the middle of the divide aborts everything
        xfer(3'd0, 8'd40, 8'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_mean", 32'(out_mean), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_release_in_ready", 32'(in_ready), 32'd1);
        expect_quiet("abort_no_output", 20);
        xfer(3'd0, 8'd40, 8'h55);
        expect_result("after_abort", 3'd0, 8'd40, 4'd0, 1'b0);
        take_result("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
